sevenseg_scan_ctrl: RTL and testbench
=====================================

Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode 7-segment display on the Boolean/Nexys board.
- Holds a CPU-writable shadow digit buffer and an active digit buffer.
- Copies shadow to active only at frame boundaries, so updates never tear.
- Sequences the anodes one digit at a time, with programmable brightness and a fixed inter-digit blanking gap for de-ghosting.
- Sits between the GPIO-driven register interface and the AN/seg/dp pins.

Parameters:
NUM_DIGITS, 8, digits scanned (1-8); unused anodes held high.
DIGIT_TICKS, 100000, clk cycles in the lit window of one digit slot at full brightness.
BLANK_TICKS, 4, clk cycles of forced blanking at the end of every slot (>=1).

Ports:
clk  in  1  system clock (100 MHz).
reset  in  1  synchronous, active-high reset.
enable  in  1  scanning enable; 0 forces the display dark.
wr_en  in  1  single-cycle shadow-buffer write strobe.
wr_addr  in  3  digit index for the write (0 = rightmost, an[0]).
wr_data  in  8  [3:0] hex value, [4] dp on, [5] blank, [7:6] reserved/ignored.
commit  in  1  pulse: request shadow-to-active copy at the next frame boundary.
brightness  in  4  lit fraction, (brightness+1)/16 of DIGIT_TICKS.
an  out  8  anodes, active low.
seg  out  7  cathodes {g,f,e,d,c,b,a}, active low.
dp  out  1  decimal point, active low.
frame_done  out  1  one-cycle pulse at the end of each frame.
commit_pending  out  1  high from commit until the copy completes.

Behaviour:
- Reset values:
  - an=8'hFF, seg=7'h7F, dp=1, frame_done=0, commit_pending=0.
  - All shadow and active entries = blank (bit5=1).
  - State IDLE, digit=0, tick=0, latched brightness=15.
- States:
  - IDLE: outputs dark. If enable=1, go to ON at digit 0; this entry is a frame boundary.
  - ON: lit for on_ticks = ((brightness_l+1)*DIGIT_TICKS)>>4 cycles, minimum 1. Then go to GAP.
  - GAP: dark for (DIGIT_TICKS - on_ticks + BLANK_TICKS) cycles. Then advance the digit and go to ON.
  - Slot length is always DIGIT_TICKS+BLANK_TICKS.
- Frame end:
  - When the GAP of digit NUM_DIGITS-1 completes, frame_done=1 for exactly that cycle.
  - Digit wraps to 0 on the same cycle; this is a frame boundary.
- At every frame boundary:
  - brightness is sampled into brightness_l.
  - If commit_pending=1 or commit=1 that cycle, the shadow buffer is copied to active and commit_pending clears.
- enable=0 in any state: the next cycle goes to IDLE with outputs dark; tick and digit reset to 0. A pending commit is retained.
- Writes:
  - Take effect in shadow on the cycle after wr_en.
  - A write coinciding with a copy does not reach active; the copy uses the pre-write shadow contents.
  - Reserved bits are ignored.
- commit while commit_pending=1: no additional effect.
- Outputs in ON for the current digit d:
  - an = ~(1<<d).
  - seg = decode(active[d].value), dp = ~active[d].dp.
  - If active[d].blank=1: an stays FF, seg=7F, dp=1 (slot timing unchanged).
- Outputs in GAP and IDLE: an=FF, seg=7F, dp=1.
- All outputs are registered. Pin change lags the state/tick change by 1 cycle, and this lag is the same at every transition.
- Decode, a..g active low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06, F=0E.
  - Values given as hex of {g..a}.
- Counter widths: $clog2(DIGIT_TICKS+BLANK_TICKS+1). The on_ticks multiply is done at full width before the shift.
- reset asserted mid-operation: full return to reset values on the next edge, including pending commits and shadow contents.

Decomposition:
- Package sevenseg_pkg:
  - scan_state_t enum (IDLE, ON, GAP).
  - wr_data field indices (VAL_LSB/MSB, DP_BIT, BLANK_BIT).
  - SEG_OFF=7'h7F, AN_OFF=8'hFF.
  - Hex-to-segment constant table.
- Sub-module sevenseg_hex_decode: combinational 4-bit to 7-bit active-low decoder, also reused by other display blocks.

Test Plan:
All scenarios use DIGIT_TICKS=16, BLANK_TICKS=2, NUM_DIGITS=8: slot = 18 cycles, frame = 144 cycles.
1. Hold reset 5 cycles with enable=1 -> an=FF, seg=7F, dp=1 throughout. Release with enable=0 for 50 cycles -> still dark, frame_done never pulses.
2. Write addr0=0x01, addr1=0x1A (dp on), commit, then enable, brightness=15 -> an=FE, seg=79 for 16 cycles; dark 2 cycles; an=FD, seg=08, dp=0 for 16; remaining digits dark; frame_done pulses every 144 cycles.
3. brightness=7 -> each slot lit 8 cycles, dark 10. brightness=0 -> lit 1, dark 17. A change mid-frame applies only from the next frame.
4. Mid-frame (digit 3), write addr0=0x05 and pulse commit -> commit_pending=1; digit 0 keeps showing 1 until frame_done. Next frame digit 0 seg=12, commit_pending=0.
5. Drop enable during the ON phase of digit 3 -> an=FF one cycle later. Re-enable -> scan restarts at digit 0 with tick 0; a commit pending across the disable is applied at restart.
6. Assert reset with commit pending mid-scan -> all outputs dark, commit_pending=0. After release and enable, all digits stay blank until new writes and a commit.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display blocks.
package sevenseg_pkg;

  // Scan sequencer states: dark/idle, digit lit, inter-digit blanking.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // Field layout of a digit-buffer write word; bits above BLANK_BIT are ignored.
  localparam int VAL_LSB   = 0;
  localparam int VAL_MSB   = 3;
  localparam int DP_BIT    = 4;
  localparam int BLANK_BIT = 5;
  localparam int ENTRY_W   = BLANK_BIT + 1;

  // Dark levels for the active-low pins.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Buffer entry that shows nothing (blank flag set).
  localparam logic [ENTRY_W-1:0] BLANK_ENTRY = 6'b10_0000;

  // Hex digit to active-low {g,f,e,d,c,b,a} pattern.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex to active-low 7-segment decoder.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Straight table lookup; every 4-bit code has a glyph.
  always_comb begin
    seg = HEX_SEG_TABLE[hex];
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// A CPU-written shadow buffer is copied to the displayed buffer only at
// frame boundaries so an update never tears across a frame.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic [3:0] brightness,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done,
  output logic       commit_pending
);

  localparam int NUM_ENTRIES = 8;
  localparam int CW = $clog2(DIGIT_TICKS + BLANK_TICKS + 1);
  localparam int MW = CW + 5;
  localparam logic [CW-1:0] DIGIT_TICKS_C = CW'(DIGIT_TICKS);
  localparam logic [CW-1:0] BLANK_TICKS_C = CW'(BLANK_TICKS);
  localparam logic [MW-1:0] DIGIT_TICKS_W = MW'(DIGIT_TICKS);
  localparam logic [2:0]    LAST_DIGIT    = 3'(NUM_DIGITS - 1);

  scan_state_t   state_reg;
  logic [2:0]    digit_reg;
  logic [CW-1:0] tick_reg;
  logic [3:0]    brightness_l_reg;
  logic          commit_pending_reg;
  logic [7:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;
  logic          frame_done_reg;

  logic [MW-1:0] on_prod;
  logic [MW-1:0] on_full;
  logic [CW-1:0] on_ticks;
  logic [CW-1:0] gap_ticks;
  logic          on_last;
  logic          gap_last;
  logic          frame_boundary;
  logic          copy_now;

  logic [ENTRY_W-1:0] active_arr [NUM_ENTRIES];
  logic [ENTRY_W-1:0] cur_entry;
  logic [6:0]         cur_seg;
  logic               unused_rsvd;

  // Reserved write bits carry no meaning.
  assign unused_rsvd = ^wr_data[7:6];

  // One shadow/active register pair per digit position.
  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    logic [ENTRY_W-1:0] shadow_reg;
    logic [ENTRY_W-1:0] active_reg;

    // Shadow takes CPU writes; active reloads from the pre-write shadow on a committed boundary.
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_reg <= BLANK_ENTRY;
        active_reg <= BLANK_ENTRY;
      end else begin
        if (wr_en && (wr_addr == 3'(gi))) begin
          shadow_reg <= wr_data[BLANK_BIT:VAL_LSB];
        end
        if (copy_now) begin
          active_reg <= shadow_reg;
        end
      end
    end

    assign active_arr[gi] = active_reg;
  end

  // Lit and dark lengths of a slot; multiply at full width before scaling by 1/16.
  always_comb begin
    on_prod   = MW'({1'b0, brightness_l_reg} + 5'd1) * DIGIT_TICKS_W;
    on_full   = on_prod >> 4;
    on_ticks  = (on_full == '0) ? CW'(1) : on_full[CW-1:0];
    gap_ticks = DIGIT_TICKS_C - on_ticks + BLANK_TICKS_C;
  end

  // Phase-end detection, frame boundary and the commit copy decision.
  always_comb begin
    on_last        = (tick_reg == (on_ticks - CW'(1)));
    gap_last       = (tick_reg == (gap_ticks - CW'(1)));
    frame_boundary = enable &&
                     ((state_reg == IDLE) ||
                      ((state_reg == GAP) && gap_last && (digit_reg == LAST_DIGIT)));
    copy_now       = frame_boundary && (commit_pending_reg || commit);
    cur_entry      = active_arr[digit_reg];
  end

  sevenseg_hex_decode u_hex_decode (
    .hex (cur_entry[VAL_MSB:VAL_LSB]),
    .seg (cur_seg)
  );

  // Scan sequencer with registered pins: pins always show the previous cycle's phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      digit_reg          <= '0;
      tick_reg           <= '0;
      brightness_l_reg   <= 4'hF;
      commit_pending_reg <= 1'b0;
      an_reg             <= AN_OFF;
      seg_reg            <= SEG_OFF;
      dp_reg             <= 1'b1;
      frame_done_reg     <= 1'b0;
    end else begin
      an_reg         <= AN_OFF;
      seg_reg        <= SEG_OFF;
      dp_reg         <= 1'b1;
      frame_done_reg <= 1'b0;

      if (frame_boundary) begin
        brightness_l_reg <= brightness;
      end

      if (copy_now) begin
        commit_pending_reg <= 1'b0;
      end else if (commit) begin
        commit_pending_reg <= 1'b1;
      end

      if (!enable) begin
        state_reg <= IDLE;
        digit_reg <= '0;
        tick_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= ON;
            digit_reg <= '0;
            tick_reg  <= '0;
          end
          ON: begin
            if (!cur_entry[BLANK_BIT]) begin
              an_reg  <= ~(8'd1 << digit_reg);
              seg_reg <= cur_seg;
              dp_reg  <= ~cur_entry[DP_BIT];
            end
            if (on_last) begin
              state_reg <= GAP;
              tick_reg  <= '0;
            end else begin
              tick_reg <= tick_reg + CW'(1);
            end
          end
          GAP: begin
            if (gap_last) begin
              state_reg      <= ON;
              tick_reg       <= '0;
              frame_done_reg <= (digit_reg == LAST_DIGIT);
              digit_reg      <= (digit_reg == LAST_DIGIT) ? 3'd0 : digit_reg + 3'd1;
            end else begin
              tick_reg <= tick_reg + CW'(1);
            end
          end
          default: begin
            state_reg <= IDLE;
            digit_reg <= '0;
            tick_reg  <= '0;
          end
        endcase
      end
    end
  end

  assign an             = an_reg;
  assign seg            = seg_reg;
  assign dp             = dp_reg;
  assign frame_done     = frame_done_reg;
  assign commit_pending = commit_pending_reg;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: a time-based reference model predicts the pins
// every cycle; scenario tasks add spec-derived spot checks.
module tb_sevenseg_scan_ctrl;

  localparam int ND    = 8;
  localparam int DT    = 16;
  localparam int BT    = 2;
  localparam int SLOT  = DT + BT;
  localparam int FRAME = SLOT * ND;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic       commit = 1'b0;
  logic [3:0] brightness = 4'hF;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;
  logic       commit_pending;

  int checks = 0;
  int passes = 0;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit         (commit),
    .brightness     (brightness),
    .an             (an),
    .seg            (seg),
    .dp             (dp),
    .frame_done     (frame_done),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  // Reference model: scan position is derived from cycles elapsed since scanning started.
  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [5:0] m_shadow [8];
  logic [5:0] m_active [8];
  logic       m_run = 1'b0;
  logic       m_pend = 1'b0;
  int         m_t = 0;
  int         m_bl = 15;
  logic [7:0] m_an = 8'hFF;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp = 1'b1;
  logic       m_fd = 1'b0;

  logic [17:0] dut_vec;
  logic [17:0] mdl_vec;
  assign dut_vec = {an, seg, dp, frame_done, commit_pending};
  assign mdl_vec = {m_an, m_seg, m_dp, m_fd, m_pend};

  function automatic void model_update();
    int   d;
    int   pos;
    int   on;
    logic bnd;
    logic cpy;
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        m_shadow[k] = 6'h20;
        m_active[k] = 6'h20;
      end
      m_run = 1'b0; m_t = 0; m_bl = 15; m_pend = 1'b0;
      m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_fd = 1'b0;
    end else begin
      m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_fd = 1'b0;
      if (enable && m_run) begin
        d   = (m_t / SLOT) % ND;
        pos = m_t % SLOT;
        on  = ((m_bl + 1) * DT) >> 4;
        if (on < 1) on = 1;
        if (pos < on && !m_active[d][5]) begin
          m_an  = ~(8'd1 << d);
          m_seg = seg_tab[m_active[d][3:0]];
          m_dp  = ~m_active[d][4];
        end
        if (m_t % FRAME == FRAME - 1) m_fd = 1'b1;
      end
      bnd = enable && (!m_run || (m_t % FRAME == FRAME - 1));
      cpy = bnd && (m_pend || commit);
      if (bnd) m_bl = int'(brightness);
      if (cpy) m_active = m_shadow;
      m_pend = cpy ? 1'b0 : (m_pend || commit);
      if (wr_en) m_shadow[wr_addr] = wr_data[5:0];
      if (!enable) begin
        m_run = 1'b0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1'b1; m_t = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
  endfunction

  // Advance one clock: model follows the edge, caller samples at the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    $display("write addr=%0d data=%h", a, d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    $display("commit request");
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    repeat (5) begin
      step();
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL reset_hold got %h want %h", dut_vec, mdl_vec);
      else passes++;
    end
    checks++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) $display("FAIL reset_pins got %h want %h", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    else passes++;
    reset = 1'b0; enable = 1'b0;
    repeat (50) begin
      step();
      checks++;
      if (dut_vec !== mdl_vec || frame_done !== 1'b0) $display("FAIL idle_dark got %h want %h", dut_vec, mdl_vec);
      else passes++;
    end
  endtask

  task automatic test_basic_scan();
    int cnt_fe = 0;
    int cnt_fd = 0;
    int fd_first = -1;
    int fd_second = -1;
    do_write(3'd0, 8'h01);
    do_write(3'd1, 8'h1A);
    do_commit();
    checks++;
    if (commit_pending !== 1'b1) $display("FAIL pending_idle got %b want 1", commit_pending);
    else passes++;
    brightness = 4'hF; enable = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL basic_scan got %h want %h", dut_vec, mdl_vec);
      else passes++;
      if (i <= FRAME) begin
        if (an == 8'hFE && seg == 7'h79 && dp) cnt_fe++;
        if (an == 8'hFD && seg == 7'h08 && !dp) cnt_fd++;
      end
      if (frame_done) begin
        if (fd_first < 0) fd_first = i;
        else if (fd_second < 0) fd_second = i;
      end
    end
    checks++;
    if (cnt_fe != 16) $display("FAIL digit0_lit got %0d want 16", cnt_fe);
    else passes++;
    checks++;
    if (cnt_fd != 16) $display("FAIL digit1_lit_dp got %0d want 16", cnt_fd);
    else passes++;
    checks++;
    if (fd_first != FRAME + 1) $display("FAIL first_frame_done got %0d want %0d", fd_first, FRAME + 1);
    else passes++;
    checks++;
    if (fd_second - fd_first != FRAME) $display("FAIL frame_period got %0d want %0d", fd_second - fd_first, FRAME);
    else passes++;
  endtask

  task automatic test_brightness();
    logic seen;
    int   cnt0;
    int   cnt1;
    int   want;
    for (int pass = 0; pass < 2; pass++) begin
      brightness = (pass == 0) ? 4'd7 : 4'd0;
      want = (pass == 0) ? 8 : 1;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        step();
        checks++;
        if (dut_vec !== mdl_vec) $display("FAIL bright_wait got %h want %h", dut_vec, mdl_vec);
        else passes++;
        if (frame_done) seen = 1'b1;
      end
      checks++;
      if (!seen) $display("FAIL bright_frame_timeout got 0 want 1");
      else passes++;
      cnt0 = 0; cnt1 = 0;
      repeat (FRAME) begin
        step();
        checks++;
        if (dut_vec !== mdl_vec) $display("FAIL bright_scan got %h want %h", dut_vec, mdl_vec);
        else passes++;
        if (an == 8'hFE) cnt0++;
        if (an == 8'hFD) cnt1++;
      end
      checks++;
      if (cnt0 != want || cnt1 != want) $display("FAIL bright_lit got %0d/%0d want %0d", cnt0, cnt1, want);
      else passes++;
    end
  endtask

  task automatic test_commit_midframe();
    logic seen;
    brightness = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL commit_sync_timeout got 0 want 1");
    else passes++;
    repeat (58) begin
      step();
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL commit_pre got %h want %h", dut_vec, mdl_vec);
      else passes++;
    end
    do_write(3'd0, 8'h05);
    do_commit();
    checks++;
    if (commit_pending !== 1'b1) $display("FAIL commit_pending_set got %b want 1", commit_pending);
    else passes++;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL commit_wait got %h want %h", dut_vec, mdl_vec);
      else passes++;
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL commit_frame_timeout got 0 want 1");
    else passes++;
    step();
    checks++;
    if ({an, seg, dp, commit_pending} !== {8'hFE, 7'h12, 1'b1, 1'b0})
      $display("FAIL commit_applied got %h want %h", {an, seg, dp, commit_pending}, {8'hFE, 7'h12, 1'b1, 1'b0});
    else passes++;
  endtask

  task automatic test_enable_drop();
    logic seen;
    int   cnt;
    do_write(3'd3, 8'h07);
    do_commit();
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL drop_wait got %h want %h", dut_vec, mdl_vec);
      else passes++;
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL drop_frame_timeout got 0 want 1");
    else passes++;
    repeat (56) step();
    checks++;
    if ({an, seg} !== {8'hF7, 7'h78}) $display("FAIL digit3_on got %h want %h", {an, seg}, {8'hF7, 7'h78});
    else passes++;
    do_write(3'd2, 8'h0C);
    do_commit();
    enable = 1'b0;
    step();
    checks++;
    if (an !== 8'hFF || dut_vec !== mdl_vec) $display("FAIL drop_dark got %h want %h", dut_vec, mdl_vec);
    else passes++;
    repeat (10) step();
    checks++;
    if (commit_pending !== 1'b1) $display("FAIL pending_kept got %b want 1", commit_pending);
    else passes++;
    enable = 1'b1;
    step();
    checks++;
    if ({an, commit_pending} !== {8'hFF, 1'b0}) $display("FAIL restart_copy got %h want %h", {an, commit_pending}, {8'hFF, 1'b0});
    else passes++;
    step();
    checks++;
    if ({an, seg} !== {8'hFE, 7'h12}) $display("FAIL restart_digit0 got %h want %h", {an, seg}, {8'hFE, 7'h12});
    else passes++;
    cnt = 0;
    repeat (60) begin
      step();
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL restart_scan got %h want %h", dut_vec, mdl_vec);
      else passes++;
      if (an == 8'hFB && seg == 7'h46) cnt++;
    end
    checks++;
    if (cnt != 16) $display("FAIL digit2_after_restart got %0d want 16", cnt);
    else passes++;
  endtask

  task automatic test_reset_midscan();
    logic seen;
    int   cnt;
    do_write(3'd5, 8'h0E);
    do_commit();
    reset = 1'b1;
    step();
    checks++;
    if ({an, seg, dp, frame_done, commit_pending} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0})
      $display("FAIL midscan_reset got %h want %h", dut_vec, {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    else passes++;
    reset = 1'b0;
    cnt = 0;
    repeat (150) begin
      step();
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL post_reset got %h want %h", dut_vec, mdl_vec);
      else passes++;
      if (an !== 8'hFF) cnt++;
    end
    checks++;
    if (cnt != 0) $display("FAIL post_reset_blank got %0d want 0", cnt);
    else passes++;
    do_write(3'd4, 8'h0B);
    do_commit();
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL rewrite_frame_timeout got 0 want 1");
    else passes++;
    cnt = 0;
    repeat (FRAME) begin
      step();
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL rewrite_scan got %h want %h", dut_vec, mdl_vec);
      else passes++;
      if (an == 8'hEF && seg == 7'h03) cnt++;
    end
    checks++;
    if (cnt != 16) $display("FAIL digit4_rewritten got %0d want 16", cnt);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_addr = 3'($urandom);
      wr_data = 8'($urandom);
      commit  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if (wr_en) $display("rand write addr=%0d data=%h commit=%b", wr_addr, wr_data, commit);
      step();
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL random got %h want %h", dut_vec, mdl_vec);
      else passes++;
    end
    wr_en = 1'b0; commit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_brightness();
    test_commit_midframe();
    test_enable_drop();
    test_reset_midscan();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
